// File: rtl/dbus_master.sv
// rtl/dbus_master.sv - data-memory bus initiator: one load/store at a time, alignment check, bus watchdog
module dbus_master #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_misalign,
  output logic [31:0] DAD,
  output logic        MREQ,
  output logic        WRITE,
  output logic [1:0]  SIZE,
  output logic [31:0] DDT_O,
  output logic        DDT_OE,
  input  logic [31:0] DDT_I,
  input  logic        ACKD_n
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_BUS} state_t;

  state_t        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic          write_q, write_d;
  logic          uns_q, uns_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          resp_valid_q, resp_valid_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          resp_err_q, resp_err_d;
  logic          resp_misalign_q, resp_misalign_d;

  logic          misaligned;
  logic [31:0]   wdata_lanes;
  logic [31:0]   load_data;

  always_comb begin
    misaligned  = 1'b0;
    wdata_lanes = 32'h0;
    case (req_size)
      2'b00: begin
        misaligned  = (req_addr[1:0] != 2'b00);
        wdata_lanes = req_wdata;
      end
      2'b01: begin
        misaligned  = req_addr[0];
        wdata_lanes = {16'h0, req_wdata[15:0]};
      end
      2'b10: wdata_lanes = {24'h0, req_wdata[7:0]};
      default: misaligned = 1'b1;
    endcase
  end

  // Responder places the lanes; only the low half/byte is meaningful for narrow loads.
  always_comb begin
    load_data = DDT_I;
    case (size_q)
      2'b01:   load_data = {{16{~uns_q & DDT_I[15]}}, DDT_I[15:0]};
      2'b10:   load_data = {{24{~uns_q & DDT_I[7]}}, DDT_I[7:0]};
      default: load_data = DDT_I;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    size_d          = size_q;
    write_d         = write_q;
    uns_d           = uns_q;
    wdata_d         = wdata_q;
    cnt_d           = cnt_q;
    resp_valid_d    = 1'b0;
    resp_rdata_d    = 32'h0;
    resp_err_d      = 1'b0;
    resp_misalign_d = 1'b0;
    req_ready       = 1'b0;
    MREQ            = 1'b0;
    DAD             = 32'h0;
    WRITE           = 1'b0;
    SIZE            = 2'b00;
    DDT_O           = 32'h0;
    DDT_OE          = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          write_d = req_write;
          uns_d   = req_unsigned;
          wdata_d = wdata_lanes;
          if (misaligned) begin
            resp_valid_d    = 1'b1;
            resp_misalign_d = 1'b1;
          end else begin
            state_d = S_BUS;
            cnt_d   = '0;
          end
        end
      end
      S_BUS: begin
        MREQ   = 1'b1;
        DAD    = addr_q;
        WRITE  = write_q;
        SIZE   = size_q;
        DDT_OE = write_q;
        DDT_O  = write_q ? wdata_q : 32'h0;
        if (!ACKD_n) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = write_q ? 32'h0 : load_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= 32'h0;
      size_q          <= 2'b00;
      write_q         <= 1'b0;
      uns_q           <= 1'b0;
      wdata_q         <= 32'h0;
      cnt_q           <= '0;
      resp_valid_q    <= 1'b0;
      resp_rdata_q    <= 32'h0;
      resp_err_q      <= 1'b0;
      resp_misalign_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      size_q          <= size_d;
      write_q         <= write_d;
      uns_q           <= uns_d;
      wdata_q         <= wdata_d;
      cnt_q           <= cnt_d;
      resp_valid_q    <= resp_valid_d;
      resp_rdata_q    <= resp_rdata_d;
      resp_err_q      <= resp_err_d;
      resp_misalign_q <= resp_misalign_d;
    end
  end

  assign resp_valid    = resp_valid_q;
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign resp_misalign = resp_misalign_q;

endmodule

// File: tb/tb_dbus_master.sv
// tb/tb_dbus_master.sv - directed bench for dbus_master
module tb_dbus_master;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_misalign;
  logic [31:0] DAD;
  logic        MREQ;
  logic        WRITE;
  logic [1:0]  SIZE;
  logic [31:0] DDT_O;
  logic        DDT_OE;
  logic [31:0] DDT_I;
  logic        ACKD_n;

  int vectors;
  int miscompares;

  dbus_master #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .resp_misalign(resp_misalign),
    .DAD(DAD), .MREQ(MREQ), .WRITE(WRITE), .SIZE(SIZE),
    .DDT_O(DDT_O), .DDT_OE(DDT_OE), .DDT_I(DDT_I), .ACKD_n(ACKD_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_resp(input string tag, input logic v, input logic [31:0] rd,
                               input logic err, input logic mis);
    chk({tag, "_resp_valid"}, {31'h0, resp_valid}, {31'h0, v});
    chk({tag, "_resp_rdata"}, resp_rdata, rd);
    chk({tag, "_resp_err"}, {31'h0, resp_err}, {31'h0, err});
    chk({tag, "_resp_misalign"}, {31'h0, resp_misalign}, {31'h0, mis});
  endtask

  // Presents a request, holds ACKD_n high for 'waits' BUS cycles, then acks.
  // Returns in the response cycle, with req_ready expected high.
  task automatic access(input string tag, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] ddt, input int waits,
                        input logic [31:0] exp_ddto, input logic [31:0] exp_rdata);
    req_valid    = 1'b1;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wd;
    DDT_I        = ddt;
    chk({tag, "_ready_before"}, {31'h0, req_ready}, 32'h1);
    step();
    req_valid = 1'b0;
    for (int i = 0; i <= waits; i++) begin
      ACKD_n = (i < waits) ? 1'b1 : 1'b0;
      chk({tag, "_MREQ"}, {31'h0, MREQ}, 32'h1);
      chk({tag, "_DAD"}, DAD, addr);
      chk({tag, "_WRITE"}, {31'h0, WRITE}, {31'h0, wr});
      chk({tag, "_SIZE"}, {30'h0, SIZE}, {30'h0, sz});
      chk({tag, "_DDT_OE"}, {31'h0, DDT_OE}, {31'h0, wr});
      chk({tag, "_DDT_O"}, DDT_O, exp_ddto);
      chk({tag, "_ready_bus"}, {31'h0, req_ready}, 32'h0);
      chk({tag, "_no_resp_in_bus"}, {31'h0, resp_valid}, 32'h0);
      step();
    end
    ACKD_n = 1'b1;
    chk({tag, "_MREQ_done"}, {31'h0, MREQ}, 32'h0);
    chk({tag, "_ready_done"}, {31'h0, req_ready}, 32'h1);
    chk_idle_resp(tag, 1'b1, exp_rdata, 1'b0, 1'b0);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    DDT_I        = 32'h0;
    ACKD_n       = 1'b1;
    step();
    step();
    rst = 1'b0;

    chk("rst_ready", {31'h0, req_ready}, 32'h1);
    chk("rst_MREQ", {31'h0, MREQ}, 32'h0);
    chk("rst_WRITE", {31'h0, WRITE}, 32'h0);
    chk("rst_SIZE", {30'h0, SIZE}, 32'h0);
    chk("rst_DAD", DAD, 32'h0);
    chk("rst_DDT_O", DDT_O, 32'h0);
    chk("rst_DDT_OE", {31'h0, DDT_OE}, 32'h0);
    chk_idle_resp("rst", 1'b0, 32'h0, 1'b0, 1'b0);

    // ACKD_n low while idle has no effect
    ACKD_n = 1'b0;
    step();
    ACKD_n = 1'b1;
    chk("idle_ack_ignored", {31'h0, resp_valid}, 32'h0);

    access("ld_word", 1'b0, 2'b00, 1'b0, 32'h0800_0010, 32'h0, 32'h1234_5678, 0, 32'h0, 32'h1234_5678);
    step();
    chk("ld_word_pulse_end", {31'h0, resp_valid}, 32'h0);

    access("ld_byte_s", 1'b0, 2'b10, 1'b0, 32'h0800_0003, 32'h0, 32'hAAAA_AA80, 0, 32'h0, 32'hFFFF_FF80);
    step();
    access("ld_byte_u", 1'b0, 2'b10, 1'b1, 32'h0800_0003, 32'h0, 32'hAAAA_AA80, 0, 32'h0, 32'h0000_0080);
    step();
    access("ld_half_s", 1'b0, 2'b01, 1'b0, 32'h0800_0002, 32'h0, 32'h0000_8001, 0, 32'h0, 32'hFFFF_8001);
    step();
    access("ld_half_u", 1'b0, 2'b01, 1'b1, 32'h5555_8002, 32'h0, 32'hFFFF_8001, 1, 32'h0, 32'h0000_8001);
    step();

    access("st_half", 1'b1, 2'b01, 1'b0, 32'h0800_0002, 32'hDEAD_BEEF, 32'hFFFF_FFFF, 3, 32'h0000_BEEF, 32'h0);
    step();
    chk("st_half_DDT_O_idle", DDT_O, 32'h0);
    chk("st_half_DDT_OE_idle", {31'h0, DDT_OE}, 32'h0);

    // Back-to-back: second request is presented in the first's response cycle
    access("st_byte_b2b", 1'b1, 2'b10, 1'b0, 32'hF000_0000, 32'h1234_5641, 32'h0, 0, 32'h0000_0041, 32'h0);
    access("st_word_b2b", 1'b1, 2'b00, 1'b0, 32'hFF00_0000, 32'hCAFE_F00D, 32'h0, 0, 32'hCAFE_F00D, 32'h0);
    step();

    // Misaligned word
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_addr = 32'h0800_0002;
    step();
    req_valid = 1'b0;
    chk("mis_word_MREQ", {31'h0, MREQ}, 32'h0);
    chk("mis_word_DAD", DAD, 32'h0);
    chk("mis_word_ready", {31'h0, req_ready}, 32'h1);
    chk_idle_resp("mis_word", 1'b1, 32'h0, 1'b0, 1'b1);
    step();
    chk("mis_word_MREQ2", {31'h0, MREQ}, 32'h0);
    chk_idle_resp("mis_word_after", 1'b0, 32'h0, 1'b0, 1'b0);

    // Illegal size on an aligned address, as a store
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b11; req_addr = 32'h0000_0000;
    step();
    req_valid = 1'b0;
    chk("mis_size_MREQ", {31'h0, MREQ}, 32'h0);
    chk("mis_size_DDT_OE", {31'h0, DDT_OE}, 32'h0);
    chk_idle_resp("mis_size", 1'b1, 32'h0, 1'b0, 1'b1);
    step();

    // Misaligned half
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b01; req_addr = 32'h0800_0001;
    step();
    req_valid = 1'b0;
    chk("mis_half_MREQ", {31'h0, MREQ}, 32'h0);
    chk_idle_resp("mis_half", 1'b1, 32'h0, 1'b0, 1'b1);
    step();

    // Watchdog: MREQ held exactly 16 cycles
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b00; req_addr = 32'h0800_0020;
    DDT_I = 32'h7777_7777; ACKD_n = 1'b1;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("to_MREQ_%0d", i), {31'h0, MREQ}, 32'h1);
      chk($sformatf("to_noresp_%0d", i), {31'h0, resp_valid}, 32'h0);
      step();
    end
    chk("to_MREQ_end", {31'h0, MREQ}, 32'h0);
    chk_idle_resp("to", 1'b1, 32'h0, 1'b1, 1'b0);
    step();
    chk_idle_resp("to_after", 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset in BUS cycle 5 of a store, coinciding with an ack
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h0800_0040;
    req_wdata = 32'h0BAD_F00D;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rb_MREQ_%0d", i), {31'h0, MREQ}, 32'h1);
      step();
    end
    chk("rb_MREQ_4", {31'h0, MREQ}, 32'h1);
    chk("rb_DDT_OE_4", {31'h0, DDT_OE}, 32'h1);
    rst = 1'b1; ACKD_n = 1'b0;
    step();
    rst = 1'b0; ACKD_n = 1'b1;
    chk("rb_MREQ", {31'h0, MREQ}, 32'h0);
    chk("rb_DDT_OE", {31'h0, DDT_OE}, 32'h0);
    chk("rb_DDT_O", DDT_O, 32'h0);
    chk("rb_DAD", DAD, 32'h0);
    chk("rb_ready", {31'h0, req_ready}, 32'h1);
    chk_idle_resp("rb", 1'b0, 32'h0, 1'b0, 1'b0);
    step();
    chk_idle_resp("rb_after", 1'b0, 32'h0, 1'b0, 1'b0);
    chk("rb_MREQ_after", {31'h0, MREQ}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dbus_master.md
# dbus_master

Core-side initiator for the data-memory bus. It accepts one load/store request at a time from the MEM stage and drives DAD/MREQ/WRITE/SIZE and the DDT byte lanes. It waits for the active-low ACKD_n from the memory responder, then returns a sign- or zero-extended load result or a store completion to the pipeline. It sits between the MEM stage and the top-level DDT tristate; alignment checking and a bus watchdog are local to this block.

## Interface
- TIMEOUT, 16: maximum BUS-state cycles without ACKD_n before the access is aborted (≥2).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  MEM stage presents a request.
- req_ready  out  1  block can accept a request (IDLE).
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 word, 01 half, 10 byte, 11 illegal.
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  bus timeout.
- resp_misalign  out  1  misaligned or illegal-size request; no bus cycle issued.
- DAD  out  32  bus address.
- MREQ  out  1  bus request.
- WRITE  out  1  1 = store cycle.
- SIZE  out  2  bus size, same encoding as req_size.
- DDT_O  out  32  store data lanes.
- DDT_OE  out  1  drive enable for the top-level DDT tristate.
- DDT_I  in  32  load data lanes.
- ACKD_n  in  1  active-low acknowledge from the responder.

## Operation
- States: IDLE, BUS. resp_* outputs are registers written on the completing edge.
- IDLE: req_ready=1. On req_valid, latch addr, size, write, unsigned and lane-formatted wdata.
  - Misaligned (word with addr[1:0]≠0, half with addr[0]=1) or req_size=11: stay IDLE and pulse resp_misalign with resp_valid next cycle. MREQ is never raised.
  - Otherwise go to BUS and clear the watchdog counter.
- BUS: MREQ=1, DAD/WRITE/SIZE from the latch, DDT_OE=WRITE.
- Store lanes: word → wdata[31:0]; half → {16'h0, wdata[15:0]}; byte → {24'h0, wdata[7:0]}. DDT_O is 0 when not storing.
- Load lanes: word → DDT_I; half → ext(DDT_I[15:0]); byte → ext(DDT_I[7:0]). ext is zero- or sign-extension per unsigned. Upper lanes of DDT_I are ignored for half and byte loads.
- The block does no byte-address remapping within the word; the responder owns lane placement.
- Rising edge in BUS with ACKD_n=0: capture the result, go to IDLE, and drive resp_valid=1 the next cycle. resp_rdata=0 for stores.
- Rising edge in BUS with ACKD_n=1: counter+1. When the counter reaches TIMEOUT-1 and ACKD_n is still 1, go to IDLE with resp_valid=1, resp_err=1, resp_rdata=0.
- ACKD_n is ignored outside BUS.
- Requests presented while in BUS are not accepted (req_ready=0). The requester holds them.

## Timing
- Reset values: state IDLE, req_ready=1, MREQ=0, WRITE=0, SIZE=00, DAD=0, DDT_O=0, DDT_OE=0, resp_valid=0, resp_rdata=0, resp_err=0, resp_misalign=0, counter 0.
- Zero-wait access: accept at edge N, MREQ high in cycle N+1, ACKD_n sampled low at edge N+1, resp_valid in cycle N+2. req_ready=1 in cycle N+2, so back-to-back throughput is one access per 2 cycles.
- k wait cycles: MREQ and all bus outputs stay stable for k+1 cycles. resp_valid follows 1 cycle after the acknowledging edge.
- Misaligned request: resp_valid 1 cycle after acceptance; bus outputs unchanged.
- Timeout: MREQ high exactly TIMEOUT cycles; resp_err pulses the cycle after.
- resp_valid is always a single-cycle pulse and never overlaps MREQ=1.
- rst during BUS: on that edge MREQ, DDT_OE and all outputs take their reset values. No response is produced and the aborted access is lost.
- rst dominates an accept or an ACKD_n on the same edge.

## Test plan
- Word load at 0x0800_0010, ACKD_n=0 in the first BUS cycle, DDT_I=0x1234_5678 → MREQ=1 WRITE=0 SIZE=00 DAD=0x0800_0010 for 1 cycle; resp_valid next cycle with resp_rdata=0x1234_5678.
- Byte load at 0x0800_0003, DDT_I=0xAAAA_AA80: signed → 0xFFFF_FF80; unsigned → 0x0000_0080. Half load at 0x0800_0002, DDT_I=0x0000_8001, signed → 0xFFFF_8001.
- Half store at 0x0800_0002, wdata 0xDEAD_BEEF, ACKD_n held high 3 cycles then low → DDT_OE=1, DDT_O=0x0000_BEEF, SIZE=01, WRITE=1 stable for 4 cycles; resp_valid with resp_rdata=0.
- Byte store of 0x41 to 0xF000_0000 back-to-back with a word store to 0xFF00_0000 → second MREQ rises exactly 2 cycles after the first completes; DDT_O=0x0000_0041 then the full word.
- Word load at 0x0800_0002 and any req_size=11 → MREQ stays 0; resp_valid plus resp_misalign 1 cycle after acceptance.
- ACKD_n never asserted (TIMEOUT=16) → MREQ high 16 cycles, then resp_err=1, resp_rdata=0. Repeat with rst at BUS cycle 5 → MREQ=0 after that edge, no resp_valid, req_ready=1.
